// File: rtl/requant_writer_if.sv
// Bus bundle for requant_writer: start/operand handshake, C buffer read port, D buffer write port.
interface requant_writer_if #(
  parameter int C_ADDR_BITS = 13,
  parameter int D_ADDR_BITS = 13
);
  logic                   in_valid;
  logic [C_ADDR_BITS-1:0] start_addr;
  logic [C_ADDR_BITS-1:0] count;
  logic [D_ADDR_BITS-1:0] d_base;
  logic [31:0]            bias;
  logic [31:0]            multiplier;
  logic [4:0]             shift;
  logic [31:0]            output_offset;
  logic [7:0]             act_min;
  logic [7:0]             act_max;
  logic                   busy;
  logic                   done;
  logic [C_ADDR_BITS-1:0] C_index;
  logic [127:0]           C_data_out;
  logic                   D_wr_en;
  logic [D_ADDR_BITS-1:0] D_index;
  logic [31:0]            D_data_in;

  modport master (
    output in_valid, start_addr, count, d_base, bias, multiplier, shift,
           output_offset, act_min, act_max, C_data_out,
    input  busy, done, C_index, D_wr_en, D_index, D_data_in
  );

  modport slave (
    input  in_valid, start_addr, count, d_base, bias, multiplier, shift,
           output_offset, act_min, act_max, C_data_out,
    output busy, done, C_index, D_wr_en, D_index, D_data_in
  );
endinterface

// File: rtl/requant_writer.sv
// Requantizes int32 accumulators (4 lanes per C word) to int8 and writes packed words to D.
// One entry per READ/CALC/WRITE triple; per-lane math lives in requant_lane.
module requant_lane (
  input  logic [31:0] acc,
  input  logic [31:0] bias,
  input  logic [31:0] multiplier,
  input  logic [31:0] output_offset,
  input  logic [4:0]  shift,
  input  logic [7:0]  act_min,
  input  logic [7:0]  act_max,
  output logic [7:0]  q
);
  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;

  logic signed [31:0] x, m, y, ys, z, lo, hi;
  logic signed [63:0] p, s;
  logic [31:0]        mask, rem, thr;
  logic               sat;

  always_comb begin
    x   = acc + bias;
    m   = multiplier;
    sat = (x == 32'sh80000000) && (m == 32'sh80000000);
    p   = {{32{x[31]}}, x} * {{32{m[31]}}, m};
    s   = p + (p[63] ? NUDGE_NEG : NUDGE_POS);
    // s>>>31 floors; bump negatives with a nonzero remainder to truncate toward zero
    y   = sat ? 32'sh7FFFFFFF : $signed(s[62:31]) + {31'd0, s[63] && (s[30:0] != '0)};
    mask = (32'd1 << shift) - 32'd1;
    rem  = y & mask;
    thr  = (mask >> 1) + {31'd0, y[31]};
    ys   = y >>> shift;
    z    = ys + {31'd0, rem > thr} + output_offset;
    lo   = {{24{act_min[7]}}, act_min};
    hi   = {{24{act_max[7]}}, act_max};
    q    = z[7:0];
    if (z < lo)      q = act_min;
    else if (z > hi) q = act_max;
  end
endmodule

module requant_writer #(
  parameter int C_ADDR_BITS = 13,
  parameter int D_ADDR_BITS = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  requant_writer_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam logic [C_ADDR_BITS-1:0] ONE_C = 1;

  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

  state_t                 state, state_n;
  logic [C_ADDR_BITS-1:0] k, k_n;
  logic [C_ADDR_BITS-1:0] c_index_q, c_index_n;
  logic [D_ADDR_BITS-1:0] d_index_q, d_index_n;
  logic                   d_wr_en_q, d_wr_en_n;
  logic [31:0]            d_data_q, d_data_n;
  logic                   latch;

  logic [C_ADDR_BITS-1:0] start_addr_q, count_q;
  logic [D_ADDR_BITS-1:0] d_base_q;
  logic [31:0]            bias_q, mult_q, offset_q;
  logic [4:0]             shift_q;
  logic [7:0]             act_min_q, act_max_q;

  logic [NUM_LANES-1:0][7:0] lane_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // lane 0 sits in the top word of C, bottom byte of D
    requant_lane u_lane (
      .acc           (bus.C_data_out[127-32*i -: 32]),
      .bias          (bias_q),
      .multiplier    (mult_q),
      .output_offset (offset_q),
      .shift         (shift_q),
      .act_min       (act_min_q),
      .act_max       (act_max_q),
      .q             (lane_q[i])
    );
  end

  always_comb begin
    state_n   = state;
    k_n       = k;
    c_index_n = c_index_q;
    d_index_n = d_index_q;
    d_wr_en_n = 1'b0;
    d_data_n  = d_data_q;
    latch     = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        latch = 1'b1;
        k_n   = '0;
        if (bus.count == '0) state_n = DONE;
        else begin
          state_n   = READ;
          c_index_n = bus.start_addr;
        end
      end
      READ: state_n = CALC;
      CALC: begin
        state_n   = WRITE;
        d_data_n  = lane_q;
        d_wr_en_n = 1'b1;
        d_index_n = d_base_q + D_ADDR_BITS'(k);
      end
      WRITE: begin
        if (k == count_q - ONE_C) state_n = DONE;
        else begin
          state_n   = READ;
          k_n       = k + ONE_C;
          c_index_n = start_addr_q + k + ONE_C;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      c_index_q    <= '0;
      d_index_q    <= '0;
      d_wr_en_q    <= 1'b0;
      d_data_q     <= '0;
      start_addr_q <= '0;
      count_q      <= '0;
      d_base_q     <= '0;
      bias_q       <= '0;
      mult_q       <= '0;
      shift_q      <= '0;
      offset_q     <= '0;
      act_min_q    <= '0;
      act_max_q    <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      c_index_q <= c_index_n;
      d_index_q <= d_index_n;
      d_wr_en_q <= d_wr_en_n;
      d_data_q  <= d_data_n;
      if (latch) begin
        start_addr_q <= bus.start_addr;
        count_q      <= bus.count;
        d_base_q     <= bus.d_base;
        bias_q       <= bus.bias;
        mult_q       <= bus.multiplier;
        shift_q      <= bus.shift;
        offset_q     <= bus.output_offset;
        act_min_q    <= bus.act_min;
        act_max_q    <= bus.act_max;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.C_index   = c_index_q;
  assign bus.D_index   = d_index_q;
  assign bus.D_wr_en   = d_wr_en_q;
  assign bus.D_data_in = d_data_q;
endmodule
